bnn_layer_seq: RTL and testbench



---
 rtl/bnn_pkg.sv | 28 ++
 rtl/bnn_xnor_popcount.sv | 30 +++
 rtl/bnn_layer_seq.sv | 134 +++++++++++++
 tb/tb_bnn_layer_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and derivation helpers for the sequential BNN layer.
// Exports the FSM state enum plus width and record-offset functions.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int W_LSB = 0;

  function automatic int thr_w(input int in_bits);
    return $clog2(in_bits + 1);
  endfunction

  function automatic int rec_w(input int in_bits,
                               input int load_w);
    int raw;
    raw = in_bits + thr_w(in_bits);
    return load_w * ((raw + load_w - 1) / load_w);
  endfunction

  function automatic int thr_lsb(input int in_bits);
    return in_bits;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational binary neuron: popcount of XNOR(x, w) compared to thr.
// Ports: x, w (IN_BITS) in; thr in; popcount out; fire out.
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int IN_BITS = 8,
  localparam int THR_W = thr_w(IN_BITS)
) (
  input  logic [IN_BITS-1:0] x,
  input  logic [IN_BITS-1:0] w,
  input  logic [THR_W-1:0]   thr,
  output logic [THR_W-1:0]   popcount,
  output logic               fire
);

  logic [IN_BITS-1:0] agree;

  assign agree = ~(x ^ w);

  always_comb begin
    popcount = '0;
    for (int i = 0; i < IN_BITS; i++) begin
      popcount = popcount + THR_W'(agree[i]);
    end
  end

  // unsigned: thr=0 always fires, thr>IN_BITS never does
  assign fire = (popcount >= thr);

endmodule

// File: rtl/bnn_layer_seq.sv
// Time-multiplexed BNN layer: one XNOR-popcount unit, one neuron/cycle.
// Ports: clk, reset, in_* / out_* handshakes, nibble-serial load port.
module bnn_layer_seq
  import bnn_pkg::*;
#(
  parameter int IN_BITS = 8,
  parameter int NUM_NEURONS = 8,
  parameter int LOAD_W = 4,
  localparam int THR_W = thr_w(IN_BITS),
  localparam int IDX_W =
    (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IN_BITS-1:0]     in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM_NEURONS-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [LOAD_W-1:0]      load_data,
  input  logic                   load_valid,
  input  logic                   load_rewind,
  output logic [IDX_W-1:0]       load_idx
);

  localparam int REC_W = rec_w(IN_BITS, LOAD_W);
  localparam int NIB = REC_W / LOAD_W;
  localparam int BUF_W = REC_W - LOAD_W;
  localparam int NC_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int THR_LSB = thr_lsb(IN_BITS);

  state_t state;
  state_t state_nx;

  logic [IN_BITS-1:0] in_reg;
  logic [IN_BITS-1:0] w_mem [NUM_NEURONS];
  logic [THR_W-1:0]   thr_mem [NUM_NEURONS];

  logic [BUF_W-1:0] rec_buf;
  logic [REC_W-1:0] rec_nx;
  logic [NC_W-1:0]  nib_cnt;
  logic [IDX_W-1:0] k;

  logic in_fire;
  logic out_fire;
  logic load_ok;
  logic last_nib;
  logic k_last;
  logic fire;

  assign in_ready = (state == IDLE) &&
                    (nib_cnt == '0) &&
                    !load_valid;
  assign out_valid = (state == DONE);
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign load_ok = (state == IDLE) && load_valid;
  assign last_nib = (nib_cnt == NC_W'(NIB - 1));
  assign k_last = (k == IDX_W'(NUM_NEURONS - 1));

  // newest nibble enters at the top, so the first nibble ends up at bit 0
  assign rec_nx = {load_data, rec_buf};

  bnn_xnor_popcount #(
    .IN_BITS (IN_BITS)
  ) u_neuron (
    .x        (in_reg),
    .w        (w_mem[k]),
    .thr      (thr_mem[k]),
    .popcount (),
    .fire     (fire)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_fire) state_nx = RUN;
      RUN:  if (k_last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_reg <= '0;
      out_data <= '0;
      k <= '0;
      rec_buf <= '0;
      nib_cnt <= '0;
      load_idx <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        w_mem[i] <= '0;
        thr_mem[i] <= '0;
      end
    end else begin
      state <= state_nx;

      if (in_fire) begin
        in_reg <= in_data;
        out_data <= '0;
      end

      if (state == RUN) begin
        out_data[k] <= fire;
        k <= k_last ? '0 : k + 1'b1;
      end

      if (load_rewind) begin
        load_idx <= '0;
        nib_cnt <= '0;
      end else if (load_ok) begin
        rec_buf <= rec_nx[REC_W-1:LOAD_W];
        if (last_nib) begin
          nib_cnt <= '0;
          w_mem[load_idx] <= rec_nx[W_LSB +: IN_BITS];
          thr_mem[load_idx] <= rec_nx[THR_LSB +: THR_W];
          load_idx <= (load_idx == IDX_W'(NUM_NEURONS - 1))
                      ? '0 : load_idx + 1'b1;
        end else begin
          nib_cnt <= nib_cnt + 1'b1;
        end
      end
    end
  end

  // out_fire is implied by the DONE->IDLE transition above
  logic unused_ok;
  assign unused_ok = out_fire;

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed self-checking bench for bnn_layer_seq (8 inputs, 8 neurons).
// One task per scenario, called in order from a single initial block.
module tb_bnn_layer_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] load_data;
  logic       load_valid;
  logic       load_rewind;
  logic [2:0] load_idx;

  int checks = 0;
  int errors = 0;

  bnn_layer_seq #(
    .IN_BITS     (8),
    .NUM_NEURONS (8),
    .LOAD_W      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_rewind (load_rewind),
    .load_idx    (load_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_nib(input logic [3:0] d);
    load_valid = 1'b1;
    load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic load_rec(input logic [7:0] w,
                          input logic [3:0] thr);
    logic [11:0] r;
    r = {thr, w};
    for (int i = 0; i < 3; i++) load_nib(r[i*4 +: 4]);
  endtask

  task automatic rewind();
    load_rewind = 1'b1;
    tick();
    load_rewind = 1'b0;
  endtask

  task automatic infer(input logic [7:0] x,
                       input logic [7:0] exp,
                       input string nm);
    int n;
    int lat;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready got %b exp 1", nm, in_ready);
    end
    in_data = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL %s_latency got %0d exp 9", nm, lat);
    end
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL %s_data got %h exp %h", nm, out_data, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release got rdy=%b vld=%b exp 1/0",
               nm, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 ||
        in_ready !== 1'b1 || load_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_vals got v=%b d=%h r=%b i=%0d exp 0/00/1/0",
               out_valid, out_data, in_ready, load_idx);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got r=%b v=%b exp 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_all_fire();
    infer(8'hA5, 8'hFF, "zero_thr");
  endtask

  task automatic test_load_single();
    load_rec(8'hF0, 4'd5);
    checks++;
    if (load_idx !== 3'd1) begin
      errors++;
      $display("FAIL single_idx got %0d exp 1", load_idx);
    end
    infer(8'hF0, 8'hFF, "n0_match");
    infer(8'h0F, 8'hFE, "n0_miss");
  endtask

  task automatic test_wrap();
    rewind();
    for (int i = 0; i < 8; i++) load_rec(8'hFF, 4'(i + 1));
    checks++;
    if (load_idx !== 3'd0) begin
      errors++;
      $display("FAIL wrap_idx got %0d exp 0", load_idx);
    end
    load_rec(8'h00, 4'd8);
    checks++;
    if (load_idx !== 3'd1) begin
      errors++;
      $display("FAIL ninth_idx got %0d exp 1", load_idx);
    end
    infer(8'hFF, 8'hFE, "wrap_ff");
    infer(8'h00, 8'h01, "wrap_00");
    infer(8'h0F, 8'h0E, "wrap_0f");
  endtask

  task automatic test_thresholds();
    rewind();
    load_rec(8'hFF, 4'd8);
    load_rec(8'hFF, 4'd9);
    checks++;
    if (load_idx !== 3'd2) begin
      errors++;
      $display("FAIL thr_idx got %0d exp 2", load_idx);
    end
    infer(8'hFF, 8'hFD, "thr_ff");
    infer(8'h7F, 8'h7C, "thr_7f");
  endtask

  task automatic test_stall();
    int lat;
    in_data = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL stall_latency got %0d exp 9", lat);
    end
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data = 4'hA;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hFD ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b d=%h r=%b exp 1/fd/0",
                 i, out_valid, out_data, in_ready);
      end
    end
    load_valid = 1'b0;
    checks++;
    if (load_idx !== 3'd2) begin
      errors++;
      $display("FAIL stall_idx got %0d exp 2", load_idx);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got r=%b v=%b exp 1/0",
               in_ready, out_valid);
    end
    infer(8'hFF, 8'hFD, "after_stall");
  endtask

  task automatic test_rewind();
    load_nib(4'h3);
    checks++;
    if (in_ready !== 1'b0 || load_idx !== 3'd2) begin
      errors++;
      $display("FAIL partial got r=%b i=%0d exp 0/2",
               in_ready, load_idx);
    end
    rewind();
    checks++;
    if (in_ready !== 1'b1 || load_idx !== 3'd0) begin
      errors++;
      $display("FAIL rewind got r=%b i=%0d exp 1/0",
               in_ready, load_idx);
    end
    infer(8'hFF, 8'hFD, "rewind_keep");
    load_rec(8'h00, 4'd1);
    checks++;
    if (load_idx !== 3'd1) begin
      errors++;
      $display("FAIL rewind_rec_idx got %0d exp 1", load_idx);
    end
    infer(8'hFF, 8'hFC, "rewind_rec");
  endtask

  task automatic test_reset_mid_run();
    in_data = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        load_idx !== 3'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got v=%b r=%b i=%0d d=%h exp 0/1/0/00",
               out_valid, in_ready, load_idx, out_data);
    end
    infer(8'h00, 8'hFF, "weights_cleared");
  endtask

  initial begin
    reset = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    load_data = '0;
    load_valid = 1'b0;
    load_rewind = 1'b0;
    test_reset();
    test_all_fire();
    test_load_single();
    test_wrap();
    test_thresholds();
    test_stall();
    test_rewind();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
